clk_gate_ctrl: RTL



---
 rtl/clk_gate_ctrl_pkg.sv | 25 ++
 rtl/clk_gate_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the automatic clock-gate enable controller.
package clk_gate_ctrl_pkg;

    // Controller states: clock running, clock gated, and the settle window after re-enable.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        OFF    = 2'd1,
        WAKE   = 2'd2
    } state_e;

    // Default number of settle cycles spent in WAKE.
    localparam int WAKE_CYCLES_DEFAULT = 2;

    // Width of the wake counter: enough to hold WAKE_CYCLES, never narrower than one bit
    // so the counter stays a legal vector even when the settle window is disabled.
    function automatic int wake_cnt_width(input int wake_cycles);
        int w;
        w = $clog2(wake_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Wake counter width for the default settle window.
    localparam int WAKE_CNT_W_DEFAULT = wake_cnt_width(WAKE_CYCLES_DEFAULT);

endpackage

// File: rtl/clk_gate_ctrl.sv
// Automatic clock-gate enable controller. Drives the en_i of a downstream
// tc_clk_gating cell: gates the clock after a programmable run of idle cycles,
// re-enables it on a wake source and runs a 4-phase wake handshake.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  busy_i,
    input  logic                  sw_en_i,
    input  logic                  test_mode_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic                  wake_req_i,
    output logic                  wake_ack_o,
    output logic                  gate_en_o,
    output logic                  gated_o
);

    localparam int WAKE_CNT_W = wake_cnt_width(WAKE_CYCLES);
    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES);
    localparam logic [WAKE_CNT_W-1:0] WAKE_ONE  = WAKE_CNT_W'(1);

    state_e                  state;
    logic                    gate_en_q;
    logic [IDLE_CNT_W-1:0]   idle_cnt;
    logic [WAKE_CNT_W-1:0]   wake_cnt;
    logic                    idle;
    logic                    wake_src;
    logic                    thresh_hit;
    logic [IDLE_CNT_W:0]     idle_cnt_inc;

    // A pending wake request counts as activity, so a handshake can never be cut short by gating.
    assign idle     = !busy_i && !sw_en_i && !test_mode_i && !wake_req_i;
    assign wake_src = sw_en_i || test_mode_i || wake_req_i;

    // One extra bit keeps the comparison honest when the counter sits at all-ones.
    assign idle_cnt_inc = {1'b0, idle_cnt} + {{IDLE_CNT_W{1'b0}}, 1'b1};

    // Greater-or-equal so that lowering the threshold mid-count gates on the very next idle cycle.
    assign thresh_hit = (idle_thresh_i != '0) && (idle_cnt_inc >= {1'b0, idle_thresh_i});

    // Test mode bypasses the register so scan always sees a running clock.
    assign gate_en_o = gate_en_q || test_mode_i;

    // Gating FSM with idle and settle counters; every output except gate_en_o is registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ACTIVE;
            gate_en_q  <= 1'b1;
            idle_cnt   <= '0;
            wake_cnt   <= '0;
            wake_ack_o <= 1'b0;
            gated_o    <= 1'b0;
        end else begin
            wake_ack_o <= wake_req_i && (state == ACTIVE);
            case (state)
                ACTIVE: begin
                    if (!idle) begin
                        idle_cnt <= '0;
                    end else if (thresh_hit) begin
                        state     <= OFF;
                        gate_en_q <= 1'b0;
                        gated_o   <= 1'b1;
                        idle_cnt  <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt_inc[IDLE_CNT_W-1:0];
                    end
                end
                OFF: begin
                    if (wake_src) begin
                        gate_en_q <= 1'b1;
                        gated_o   <= 1'b0;
                        if (WAKE_CYCLES == 0) begin
                            state <= ACTIVE;
                        end else begin
                            state    <= WAKE;
                            wake_cnt <= WAKE_LOAD;
                        end
                    end
                end
                WAKE: begin
                    if (wake_cnt <= WAKE_ONE) begin
                        state    <= ACTIVE;
                        wake_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt - WAKE_ONE;
                    end
                end
                default: begin
                    state     <= ACTIVE;
                    gate_en_q <= 1'b1;
                    gated_o   <= 1'b0;
                    idle_cnt  <= '0;
                    wake_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
